// File: rtl/line_writeback_if.sv
// AXI3 write-side channels (AW/W/B) between the write-back engine and memory.
interface line_writeback_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [3:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [ID_WIDTH-1:0]     wid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/line_writeback.sv
// Drains one evicted cache line to memory as a single AXI3 INCR write burst.
// Optional LINE_WRITEBACK_QUERY_EN exposes the in-flight line for forwarding.
module line_writeback #(
    parameter int LINE_WIDTH = 256,
    parameter int AWID       = 2,
    parameter int BUS_WIDTH  = 4,
    // physical address width, i.e. $bits(phys_t)
    localparam int PHYS_WIDTH       = 32,
    localparam int LINE_BYTE_OFFSET = $clog2(LINE_WIDTH/8),
    localparam int LABEL_WIDTH      = PHYS_WIDTH - LINE_BYTE_OFFSET,
    localparam int BEATS            = LINE_WIDTH/32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LABEL_WIDTH-1:0] label_i,
    input  logic [LINE_WIDTH-1:0]  data_i,
    input  logic                   req_vld,
    output logic                   ready,
    output logic                   done,
    output logic                   err,
`ifdef LINE_WRITEBACK_QUERY_EN
    input  logic [LABEL_WIDTH-1:0] query_label,
    output logic                   query_hit,
    output logic [LINE_WIDTH-1:0]  query_data,
`endif
    line_writeback_if.master       axi3_wr_if
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS-1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                 state, state_nxt;
    logic [LABEL_WIDTH-1:0] label_q;
    logic [LINE_WIDTH-1:0]  line_q;
    logic [CNT_W-1:0]       cnt;
    logic                   done_q, err_q;
    logic                   last_beat;
    logic                   unused_bid;

    assign last_beat  = (cnt == LAST_BEAT);
    assign unused_bid = ^axi3_wr_if.bid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_vld)                            state_nxt = ADDR;
            ADDR: if (axi3_wr_if.awready)                 state_nxt = DATA;
            DATA: if (axi3_wr_if.wready && last_beat)     state_nxt = RESP;
            RESP: if (axi3_wr_if.bvalid)                  state_nxt = IDLE;
            default:                                      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            label_q <= '0;
            line_q  <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: if (req_vld) begin
                    label_q <= label_i;
                    line_q  <= data_i;
                    cnt     <= '0;
                end
                DATA: if (axi3_wr_if.wready) cnt <= cnt + CNT_W'(1);
                RESP: if (axi3_wr_if.bvalid) begin
                    done_q <= 1'b1;
                    err_q  <= (axi3_wr_if.bresp != 2'b00);
                end
                default: ;
            endcase
        end
    end

    // All AXI outputs decode from state and registered data only.
    always_comb begin
        ready              = 1'b0;
        axi3_wr_if.awvalid = 1'b0;
        axi3_wr_if.wvalid  = 1'b0;
        axi3_wr_if.wlast   = 1'b0;
        axi3_wr_if.bready  = 1'b0;
        case (state)
            IDLE: ready = 1'b1;
            ADDR: axi3_wr_if.awvalid = 1'b1;
            DATA: begin
                axi3_wr_if.wvalid = 1'b1;
                axi3_wr_if.wlast  = last_beat;
            end
            RESP: axi3_wr_if.bready = 1'b1;
            default: ;
        endcase
    end

    assign axi3_wr_if.awid    = BUS_WIDTH'(AWID);
    assign axi3_wr_if.awaddr  = {label_q, {LINE_BYTE_OFFSET{1'b0}}};
    assign axi3_wr_if.awlen   = 4'(BEATS-1);
    assign axi3_wr_if.awsize  = 3'b010;
    assign axi3_wr_if.awburst = 2'b01;
    assign axi3_wr_if.wid     = BUS_WIDTH'(AWID);
    assign axi3_wr_if.wdata   = line_q[32*int'(cnt) +: 32];
    assign axi3_wr_if.wstrb   = 4'hF;

    assign done = done_q;
    assign err  = err_q;

`ifdef LINE_WRITEBACK_QUERY_EN
    assign query_hit  = (state != IDLE) && (query_label == label_q);
    assign query_data = line_q;
`endif

endmodule
